controle_execucao: RTL and testbench
====================================

// Module: controle_execucao
// PURPOSE
//  Execution sequencer between the FPGA board and the single-cycle processor datapath.
//  Generates the one-cycle `clock` tick pulse that advances PC, register bank and data memory.
//  Tick source: free-running divider (run mode) or a debounced push-button (single-step mode).
//  Stops at break instructions. Stalls on input instructions until the user confirms the switch value.
// PARAMETERS
//  DIVISOR   25000000  clkFPGA cycles per tick in run mode (>=2)
//  DEBOUNCE  500000    cycles a button must be stable before a press is accepted (>=1)
// PORTS
//  clkFPGA        in   1   board clock; only clock of the block
//  Reset          in   1   asynchronous, active-low; clears all state
//  modoPasso      in   1   switch (async): 1 = single-step, 0 = run
//  botaoPasso     in   1   raw button, active-high: step / resume from breakpoint
//  botaoEntrada   in   1   raw button, active-high: confirm input value
//  entradaFPGA    in   5   raw input switches
//  BreakFlag      in   1   from control unit: current instruction is break
//  EntradaFlag    in   1   from control unit: current instruction reads input
//  SaidaPC        in   32  current PC
//  pontoParada    in   32  breakpoint address (only with PONTO_PARADA_EN)
//  clock          out  1   datapath tick: high exactly one clkFPGA cycle per instruction
//  entradaLatch   out  32  {27'b0, entradaFPGA} captured at confirm; feeds the input mux
//  contadorCiclos out  32  ticks issued since reset; wraps 2^32-1 -> 0
//  estado         out  3   FSM state code, for display
// BEHAVIOUR
//  Reset (Reset=0): state=INICIO, clock=0, entradaLatch=0, contadorCiclos=0, divider=0,
//   debouncers and synchronizers cleared, any pending press dropped; applies mid-operation too.
//  Async inputs use a 2-FF synchronizer. Press event = debounced 0->1 edge; one event per press.
//  States (estado): INICIO=0, EXEC=1, PASSO=2, ESPERA_ENT=3, CARGA_ENT=4, PARADO=5, PONTO=6.
//  INICIO: first cycle after release -> PASSO if modoPasso, else EXEC. No tick.
//  Tick request: in EXEC when the divider reaches DIVISOR-1 (divider wraps to 0);
//   in PASSO on a botaoPasso event.
//  On a tick request, with BreakFlag/EntradaFlag sampled in the same cycle, priority is:
//   BreakFlag=1 -> PARADO, no tick;
//   else EntradaFlag=1 -> ESPERA_ENT, no tick;
//   else breakpoint hit (macro) -> PONTO, no tick;
//   else clock=1 in the next cycle and contadorCiclos+1.
//  ESPERA_ENT: on a botaoEntrada event, entradaLatch <= {27'b0, synchronized entradaFPGA}
//   and go to CARGA_ENT. botaoPasso is ignored.
//  CARGA_ENT: clock=1 for one cycle, contadorCiclos+1, then return to EXEC/PASSO per modoPasso.
//   entradaLatch holds its value until the next confirm.
//  PARADO: terminal. No ticks; buttons ignored; exit only via Reset.
//  modoPasso change in EXEC/PASSO takes effect at once: divider cleared, no tick that cycle.
//   A change during ESPERA_ENT is honoured at the exit from CARGA_ENT.
//  Tick latency: 1 clkFPGA cycle after the request; ticks are never back-to-back.
// CONFIGURATION
//  PONTO_PARADA_EN defined:
//   - port pontoParada exists.
//   - Breakpoint hit = tick request while SaidaPC == pontoParada.
//   - PONTO: a botaoPasso event issues one tick (counted) and returns to EXEC/PASSO,
//     so the breakpoint is passed once; the next hit at the same address stops again.
//  PONTO_PARADA_EN undefined: no pontoParada port, no PONTO state, no comparator.
// STRUCTURE
//  controle_defs.vh: state codes (3-bit localparams) and ESTADO_W=3; shared with the display logic.
//  Sub-module filtro_botao (sync + debounce counter + rising-edge pulse; parameter DEBOUNCE),
//   instantiated once per button. The modoPasso switch uses a plain 2-FF synchronizer.
// TESTING (DIVISOR=4, DEBOUNCE=3)
//  - Reset=0 then 1, modoPasso=0, flags 0 -> one clock pulse every 4 cycles;
//    contadorCiclos=3 after 3 pulses.
//  - modoPasso=1, botaoPasso bounce 1-0-1 then held for 10 cycles -> exactly one pulse,
//    estado=2.
//  - EntradaFlag=1 at a request -> estado=3, no pulse; entradaFPGA=5'h15 then botaoEntrada
//    press -> entradaLatch=32'h15, one pulse, estado back to 1.
//  - BreakFlag=1 and EntradaFlag=1 at the same request -> estado=5, no pulse; buttons
//    produce nothing; Reset pulse -> contadorCiclos=0, estado=0.
//  - PONTO_PARADA_EN, pontoParada=32'h8, SaidaPC=8 at a request -> estado=6; botaoPasso press
//    -> one pulse, estado=1.
//  - Reset asserted during ESPERA_ENT with a press mid-debounce -> all outputs 0; no pulse
//    after release.

Source files
------------

// File: rtl/controle_execucao_pkg.sv
// Shared definitions for the execution sequencer: state codes (also used by the
// board display logic) and a width helper.
// Optional feature macro: PONTO_PARADA_EN (adds the PONTO breakpoint state).
package controle_execucao_pkg;

  localparam int ESTADO_W = 3;

  typedef enum logic [ESTADO_W-1:0] {
    INICIO     = 3'd0,
    EXEC       = 3'd1,
    PASSO      = 3'd2,
    ESPERA_ENT = 3'd3,
    CARGA_ENT  = 3'd4,
`ifdef PONTO_PARADA_EN
    PARADO     = 3'd5,
    PONTO      = 3'd6
`else
    PARADO     = 3'd5
`endif
  } estado_t;

  // Bits needed to count 0..n-1 (at least one bit).
  function automatic int largura(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/controle_execucao_if.sv
// Datapath-side bundle of the execution sequencer: control-unit flags and PC in,
// tick, input latch, tick counter and state code out.
// Optional feature macro: PONTO_PARADA_EN (adds the pontoParada address).
interface controle_execucao_if;

  logic                                      BreakFlag;
  logic                                      EntradaFlag;
  logic [31:0]                               SaidaPC;
`ifdef PONTO_PARADA_EN
  logic [31:0]                               pontoParada;
`endif
  logic                                      clock;
  logic [31:0]                               entradaLatch;
  logic [31:0]                               contadorCiclos;
  logic [controle_execucao_pkg::ESTADO_W-1:0] estado;

`ifdef PONTO_PARADA_EN
  modport master (
    input  BreakFlag, EntradaFlag, SaidaPC, pontoParada,
    output clock, entradaLatch, contadorCiclos, estado
  );
  modport slave (
    output BreakFlag, EntradaFlag, SaidaPC, pontoParada,
    input  clock, entradaLatch, contadorCiclos, estado
  );
`else
  modport master (
    input  BreakFlag, EntradaFlag, SaidaPC,
    output clock, entradaLatch, contadorCiclos, estado
  );
  modport slave (
    output BreakFlag, EntradaFlag, SaidaPC,
    input  clock, entradaLatch, contadorCiclos, estado
  );
`endif

endinterface

// File: rtl/controle_execucao_filtro_botao.sv
// Push-button filter: 2-FF synchronizer, debounce counter and a one-cycle event
// on each accepted 0->1 transition of the debounced level.
module filtro_botao
  import controle_execucao_pkg::*;
#(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic evento
);

  localparam int               CNT_W   = largura(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             sinc1_q, sinc1_d;
  logic             sinc2_q, sinc2_d;
  logic             estavel_q, estavel_d;
  logic             evento_q, evento_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after DEBOUNCE consecutive cycles that differ from the current one.
  always_comb begin
    sinc1_d   = botao;
    sinc2_d   = sinc1_q;
    estavel_d = estavel_q;
    cnt_d     = cnt_q;
    evento_d  = 1'b0;
    if (sinc2_q == estavel_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      estavel_d = sinc2_q;
      cnt_d     = '0;
      evento_d  = sinc2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Filter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1_q   <= 1'b0;
      sinc2_q   <= 1'b0;
      estavel_q <= 1'b0;
      evento_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sinc1_q   <= sinc1_d;
      sinc2_q   <= sinc2_d;
      estavel_q <= estavel_d;
      evento_q  <= evento_d;
      cnt_q     <= cnt_d;
    end
  end

  assign evento = evento_q;

endmodule

// File: rtl/controle_execucao.sv
// Execution sequencer: issues the one-cycle datapath tick from a free-running
// divider (run mode) or a debounced step button, stops on break instructions and
// stalls on input instructions until the user confirms the switch value.
// Optional feature macro: PONTO_PARADA_EN (breakpoint address with PONTO state).
module controle_execucao
  import controle_execucao_pkg::*;
#(
  parameter int DIVISOR  = 25000000,
  parameter int DEBOUNCE = 500000
) (
  input  logic                 clkFPGA,
  input  logic                 Reset,
  input  logic                 modoPasso,
  input  logic                 botaoPasso,
  input  logic                 botaoEntrada,
  input  logic [4:0]           entradaFPGA,
  controle_execucao_if.master  dp
);

  localparam int               DIV_W   = largura(DIVISOR);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIVISOR - 1);

  estado_t          estado_q, estado_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clock_q, clock_d;
  logic [31:0]      latch_q, latch_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             modo_s1_q, modo_s1_d, modo_q, modo_d;
  logic [4:0]       ent_s1_q, ent_s1_d, ent_q, ent_d;
  logic             ev_passo, ev_entrada;
  logic             pedido;
  logic             parada_hit;

  filtro_botao #(.DEBOUNCE(DEBOUNCE)) u_filtro_passo (
    .clk(clkFPGA), .rst_n(Reset), .botao(botaoPasso), .evento(ev_passo)
  );

  filtro_botao #(.DEBOUNCE(DEBOUNCE)) u_filtro_entrada (
    .clk(clkFPGA), .rst_n(Reset), .botao(botaoEntrada), .evento(ev_entrada)
  );

`ifdef PONTO_PARADA_EN
  assign parada_hit = (dp.SaidaPC == dp.pontoParada);
`else
  // The PC only matters to the breakpoint comparator.
  logic unused_pc;
  assign unused_pc  = ^dp.SaidaPC;
  assign parada_hit = 1'b0;
`endif

  // Next state, divider, tick and counters; a tick request is resolved against the flags.
  always_comb begin
    estado_d  = estado_q;
    div_d     = '0;
    clock_d   = 1'b0;
    latch_d   = latch_q;
    cnt_d     = cnt_q;
    modo_s1_d = modoPasso;
    modo_d    = modo_s1_q;
    ent_s1_d  = entradaFPGA;
    ent_d     = ent_s1_q;
    pedido    = 1'b0;
    case (estado_q)
      INICIO:     estado_d = modo_q ? PASSO : EXEC;
      EXEC: begin
        if (modo_q)                estado_d = PASSO;
        else if (div_q == DIV_MAX) pedido   = 1'b1;
        else                       div_d    = div_q + DIV_W'(1);
      end
      // A press landing on the cycle right after a tick is dropped so ticks never touch.
      PASSO: begin
        if (!modo_q) estado_d = EXEC;
        else         pedido   = ev_passo && !clock_q;
      end
      ESPERA_ENT: begin
        if (ev_entrada) begin
          latch_d  = {27'b0, ent_q};
          estado_d = CARGA_ENT;
        end
      end
      CARGA_ENT: begin
        clock_d  = 1'b1;
        cnt_d    = cnt_q + 32'd1;
        estado_d = modo_q ? PASSO : EXEC;
      end
      PARADO:     estado_d = PARADO;
`ifdef PONTO_PARADA_EN
      PONTO: begin
        if (ev_passo) begin
          clock_d  = 1'b1;
          cnt_d    = cnt_q + 32'd1;
          estado_d = modo_q ? PASSO : EXEC;
        end
      end
`endif
      default:    estado_d = INICIO;
    endcase
    if (pedido) begin
      if (dp.BreakFlag)        estado_d = PARADO;
      else if (dp.EntradaFlag) estado_d = ESPERA_ENT;
`ifdef PONTO_PARADA_EN
      else if (parada_hit)     estado_d = PONTO;
`endif
      else begin
        clock_d = 1'b1;
        cnt_d   = cnt_q + 32'd1;
      end
    end
  end

  // State register; Reset clears everything, including mid-operation.
  always_ff @(posedge clkFPGA or negedge Reset) begin
    if (!Reset) begin
      estado_q  <= INICIO;
      div_q     <= '0;
      clock_q   <= 1'b0;
      latch_q   <= '0;
      cnt_q     <= '0;
      modo_s1_q <= 1'b0;
      modo_q    <= 1'b0;
      ent_s1_q  <= '0;
      ent_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      div_q     <= div_d;
      clock_q   <= clock_d;
      latch_q   <= latch_d;
      cnt_q     <= cnt_d;
      modo_s1_q <= modo_s1_d;
      modo_q    <= modo_d;
      ent_s1_q  <= ent_s1_d;
      ent_q     <= ent_d;
    end
  end

  assign dp.clock          = clock_q;
  assign dp.entradaLatch   = latch_q;
  assign dp.contadorCiclos = cnt_q;
  assign dp.estado         = estado_q;

endmodule

// File: tb/tb_controle_execucao.sv
// Self-checking bench for controle_execucao (DIVISOR=4, DEBOUNCE=3).
// Expected tick counts come from the period rule (one tick every DIVISOR cycles
// after a known tick), one tick per accepted press, and the state rules.
module tb_controle_execucao;

  localparam int DIVISOR  = 4;
  localparam int DEBOUNCE = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       modo  = 1'b0;
  logic       bp    = 1'b0;
  logic       be    = 1'b0;
  logic [4:0] ent   = 5'd0;

  controle_execucao_if dp();

  controle_execucao #(.DIVISOR(DIVISOR), .DEBOUNCE(DEBOUNCE)) dut (
    .clkFPGA(clk),
    .Reset(rst_n),
    .modoPasso(modo),
    .botaoPasso(bp),
    .botaoEntrada(be),
    .entradaFPGA(ent),
    .dp(dp)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          pulse_total = 0;
  int          cyc_no = 0;
  logic        clock_prev = 1'b0;
  bit          b2b_seen = 1'b0;
  logic [31:0] model_cnt = '0;
  logic [31:0] model_latch = '0;

  // One clock cycle; tallies tick pulses seen on the falling edge.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    if (dp.clock === 1'b1) begin
      pulse_total++;
      if (clock_prev === 1'b1) b2b_seen = 1'b1;
    end
    clock_prev = dp.clock;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_pulse(input int limit, output bit ok);
    int start;
    start = pulse_total;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      cyc();
      if (pulse_total != start) ok = 1'b1;
    end
  endtask

  // Press with single-cycle bounces, then hold and release.
  task automatic press(input bit which, input int glitches, input int hold);
    for (int g = 0; g < glitches; g++) begin
      if (which) be = 1'b1; else bp = 1'b1;
      cyc();
      if (which) be = 1'b0; else bp = 1'b0;
      cyc();
    end
    if (which) be = 1'b1; else bp = 1'b1;
    run_cycles(hold);
    if (which) be = 1'b0; else bp = 1'b0;
    run_cycles(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run_cycles(3);
    total++; if (dp.estado !== 3'd0) begin bad++; $display("FAIL reset_estado: got %0d expected 0", dp.estado); end
    total++; if (dp.clock !== 1'b0) begin bad++; $display("FAIL reset_clock: got %b expected 0", dp.clock); end
    total++; if (dp.entradaLatch !== 32'd0) begin bad++; $display("FAIL reset_latch: got %h expected 0", dp.entradaLatch); end
    total++; if (dp.contadorCiclos !== 32'd0) begin bad++; $display("FAIL reset_contador: got %0d expected 0", dp.contadorCiclos); end
    $display("reset: estado=%0d contador=%0d", dp.estado, dp.contadorCiclos);
    model_cnt = '0;
    model_latch = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    bit ok;
    int t_prev, t_last, k, got, exp_p, start;
    t_prev = 0;
    t_last = 0;
    for (int p = 0; p < 3; p++) begin
      wait_pulse(4 * DIVISOR, ok);
      total++; if (!ok) begin bad++; $display("FAIL run_pulse_timeout: pulse %0d not seen within %0d cycles", p + 1, 4 * DIVISOR); end
      t_prev = t_last;
      t_last = cyc_no;
    end
    model_cnt = 32'd3;
    total++; if (t_last - t_prev != DIVISOR) begin bad++; $display("FAIL run_period: got %0d cycles expected %0d", t_last - t_prev, DIVISOR); end
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL run_contador3: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
    $display("run: 3 pulses, contador=%0d", dp.contadorCiclos);
    for (int r = 0; r < 3; r++) begin
      wait_pulse(4 * DIVISOR, ok);
      total++; if (!ok) begin bad++; $display("FAIL run_align_timeout: got no pulse expected one"); end
      model_cnt = model_cnt + 32'd1;
      k = $urandom_range(5, 23);
      start = pulse_total;
      run_cycles(k);
      got = pulse_total - start;
      exp_p = k / DIVISOR;
      model_cnt = model_cnt + 32'(exp_p);
      total++; if (got != exp_p) begin bad++; $display("FAIL run_window: got %0d pulses expected %0d in %0d cycles", got, exp_p, k); end
      total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL run_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
      total++; if (dp.estado !== 3'd1) begin bad++; $display("FAIL run_estado: got %0d expected 1", dp.estado); end
      $display("run window %0d cycles: pulses=%0d contador=%0d", k, got, dp.contadorCiclos);
    end
  endtask

  task automatic test_step();
    bit ok;
    int start, n, g;
    wait_pulse(4 * DIVISOR, ok);
    total++; if (!ok) begin bad++; $display("FAIL step_align_timeout: got no pulse expected one"); end
    model_cnt = model_cnt + 32'd1;
    modo = 1'b1;
    start = pulse_total;
    run_cycles(6);
    total++; if (pulse_total != start) begin bad++; $display("FAIL step_switch_pulse: got %0d expected 0", pulse_total - start); end
    total++; if (dp.estado !== 3'd2) begin bad++; $display("FAIL step_estado: got %0d expected 2", dp.estado); end
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) begin
      g = (i == 0) ? 1 : $urandom_range(0, 3);
      start = pulse_total;
      press(1'b0, g, 10);
      model_cnt = model_cnt + 32'd1;
      total++; if (pulse_total - start != 1) begin bad++; $display("FAIL step_pulses: got %0d expected 1 (bounces %0d)", pulse_total - start, g); end
      total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL step_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
      total++; if (dp.estado !== 3'd2) begin bad++; $display("FAIL step_estado_after: got %0d expected 2", dp.estado); end
      $display("step press %0d bounces=%0d: pulses=%0d contador=%0d", i, g, pulse_total - start, dp.contadorCiclos);
    end
  endtask

  task automatic test_entrada();
    bit ok;
    int start;
    logic [4:0] val;
    modo = 1'b0;
    for (int it = 0; it < 2; it++) begin
      wait_pulse(6 * DIVISOR, ok);
      total++; if (!ok) begin bad++; $display("FAIL ent_align_timeout: got no pulse expected one"); end
      model_cnt = model_cnt + 32'd1;
      val = (it == 0) ? 5'h15 : 5'($urandom_range(0, 31));
      ent = val;
      dp.EntradaFlag = 1'b1;
      start = pulse_total;
      run_cycles(2 * DIVISOR + 2);
      total++; if (pulse_total != start) begin bad++; $display("FAIL ent_stall_pulse: got %0d expected 0", pulse_total - start); end
      total++; if (dp.estado !== 3'd3) begin bad++; $display("FAIL ent_estado_espera: got %0d expected 3", dp.estado); end
      press(1'b0, 0, 10);
      total++; if (pulse_total != start) begin bad++; $display("FAIL ent_passo_ignored: got %0d pulses expected 0", pulse_total - start); end
      total++; if (dp.estado !== 3'd3) begin bad++; $display("FAIL ent_estado_passo: got %0d expected 3", dp.estado); end
      be = 1'b1;
      wait_pulse(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL ent_confirm_timeout: got no pulse expected one"); end
      dp.EntradaFlag = 1'b0;
      model_cnt = model_cnt + 32'd1;
      model_latch = {27'b0, val};
      total++; if (dp.entradaLatch !== model_latch) begin bad++; $display("FAIL ent_latch: got %h expected %h", dp.entradaLatch, model_latch); end
      total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL ent_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
      total++; if (dp.estado !== 3'd1) begin bad++; $display("FAIL ent_estado_exec: got %0d expected 1", dp.estado); end
      $display("entrada val=%h: latch=%h contador=%0d", val, dp.entradaLatch, dp.contadorCiclos);
      start = pulse_total;
      run_cycles(3);
      be = 1'b0;
      run_cycles(9);
      model_cnt = model_cnt + 32'(12 / DIVISOR);
      total++; if (pulse_total - start != 12 / DIVISOR) begin bad++; $display("FAIL ent_resume: got %0d pulses expected %0d", pulse_total - start, 12 / DIVISOR); end
      total++; if (dp.entradaLatch !== model_latch) begin bad++; $display("FAIL ent_latch_hold: got %h expected %h", dp.entradaLatch, model_latch); end
    end
  endtask

`ifdef PONTO_PARADA_EN
  task automatic test_ponto();
    bit ok;
    int start;
    wait_pulse(4 * DIVISOR, ok);
    total++; if (!ok) begin bad++; $display("FAIL ponto_align_timeout: got no pulse expected one"); end
    model_cnt = model_cnt + 32'd1;
    dp.pontoParada = 32'h8;
    dp.SaidaPC = 32'h8;
    start = pulse_total;
    run_cycles(2 * DIVISOR + 2);
    total++; if (pulse_total != start) begin bad++; $display("FAIL ponto_stall_pulse: got %0d expected 0", pulse_total - start); end
    total++; if (dp.estado !== 3'd6) begin bad++; $display("FAIL ponto_estado: got %0d expected 6", dp.estado); end
    bp = 1'b1;
    wait_pulse(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL ponto_resume_timeout: got no pulse expected one"); end
    dp.SaidaPC = 32'hC;
    model_cnt = model_cnt + 32'd1;
    total++; if (dp.estado !== 3'd1) begin bad++; $display("FAIL ponto_estado_exec: got %0d expected 1", dp.estado); end
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL ponto_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
    $display("ponto: estado=%0d contador=%0d", dp.estado, dp.contadorCiclos);
    start = pulse_total;
    run_cycles(3);
    bp = 1'b0;
    run_cycles(9);
    model_cnt = model_cnt + 32'(12 / DIVISOR);
    total++; if (pulse_total - start != 12 / DIVISOR) begin bad++; $display("FAIL ponto_after: got %0d pulses expected %0d", pulse_total - start, 12 / DIVISOR); end
    dp.SaidaPC = 32'h0;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int start;
    wait_pulse(4 * DIVISOR, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_align_timeout: got no pulse expected one"); end
    dp.EntradaFlag = 1'b1;
    ent = 5'($urandom_range(1, 31));
    run_cycles(2 * DIVISOR + 2);
    total++; if (dp.estado !== 3'd3) begin bad++; $display("FAIL rmid_estado_espera: got %0d expected 3", dp.estado); end
    be = 1'b1;
    run_cycles(3);
    rst_n = 1'b0;
    modo = 1'b1;
    cyc();
    be = 1'b0;
    dp.EntradaFlag = 1'b0;
    run_cycles(2);
    model_cnt = '0;
    model_latch = '0;
    total++; if (dp.clock !== 1'b0) begin bad++; $display("FAIL rmid_clock: got %b expected 0", dp.clock); end
    total++; if (dp.entradaLatch !== model_latch) begin bad++; $display("FAIL rmid_latch: got %h expected 0", dp.entradaLatch); end
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL rmid_contador: got %0d expected 0", dp.contadorCiclos); end
    total++; if (dp.estado !== 3'd0) begin bad++; $display("FAIL rmid_estado: got %0d expected 0", dp.estado); end
    rst_n = 1'b1;
    start = pulse_total;
    run_cycles(12);
    total++; if (pulse_total != start) begin bad++; $display("FAIL rmid_no_pulse: got %0d expected 0", pulse_total - start); end
    total++; if (dp.estado !== 3'd2) begin bad++; $display("FAIL rmid_estado_passo: got %0d expected 2", dp.estado); end
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL rmid_contador_after: got %0d expected 0", dp.contadorCiclos); end
    $display("reset mid-debounce: estado=%0d contador=%0d pulses=%0d", dp.estado, dp.contadorCiclos, pulse_total - start);
  endtask

  task automatic test_break();
    bit ok;
    int start;
    modo = 1'b0;
    wait_pulse(6 * DIVISOR, ok);
    total++; if (!ok) begin bad++; $display("FAIL brk_align_timeout: got no pulse expected one"); end
    model_cnt = model_cnt + 32'd1;
    dp.BreakFlag = 1'b1;
    dp.EntradaFlag = 1'b1;
    start = pulse_total;
    run_cycles(2 * DIVISOR + 2);
    total++; if (pulse_total != start) begin bad++; $display("FAIL brk_pulse: got %0d expected 0", pulse_total - start); end
    total++; if (dp.estado !== 3'd5) begin bad++; $display("FAIL brk_estado: got %0d expected 5", dp.estado); end
    press(1'b0, 0, 10);
    press(1'b1, 0, 10);
    total++; if (pulse_total != start) begin bad++; $display("FAIL brk_buttons: got %0d pulses expected 0", pulse_total - start); end
    total++; if (dp.estado !== 3'd5) begin bad++; $display("FAIL brk_estado_hold: got %0d expected 5", dp.estado); end
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL brk_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
    $display("break: estado=%0d contador=%0d", dp.estado, dp.contadorCiclos);
    rst_n = 1'b0;
    run_cycles(2);
    dp.BreakFlag = 1'b0;
    dp.EntradaFlag = 1'b0;
    model_cnt = '0;
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL brk_reset_contador: got %0d expected 0", dp.contadorCiclos); end
    total++; if (dp.estado !== 3'd0) begin bad++; $display("FAIL brk_reset_estado: got %0d expected 0", dp.estado); end
    rst_n = 1'b1;
    wait_pulse(4 * DIVISOR, ok);
    total++; if (!ok) begin bad++; $display("FAIL brk_restart_timeout: got no pulse expected one"); end
    model_cnt = model_cnt + 32'd1;
    total++; if (dp.contadorCiclos !== model_cnt) begin bad++; $display("FAIL brk_restart_contador: got %0d expected %0d", dp.contadorCiclos, model_cnt); end
    $display("break reset/restart: contador=%0d", dp.contadorCiclos);
  endtask

  initial begin
    dp.BreakFlag   = 1'b0;
    dp.EntradaFlag = 1'b0;
    dp.SaidaPC     = 32'h0;
`ifdef PONTO_PARADA_EN
    dp.pontoParada = 32'hFFFF_FFF0;
`endif
    test_reset();
    test_run();
    test_step();
    test_entrada();
`ifdef PONTO_PARADA_EN
    test_ponto();
`endif
    test_reset_mid();
    test_break();
    total++; if (b2b_seen) begin bad++; $display("FAIL back_to_back: got adjacent pulses expected none"); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
